// File: rtl/irda_mir_rx_demod.sv
// rtl/irda_mir_rx_demod.sv - MIR receive demodulator: pulse-aligned bit-cell recovery with activity flag
module irda_mir_rx_demod #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             wb_rst_n,
  input  logic             rx_pad_i,
  input  logic             rx_invert,
  input  logic             mir_en,
  input  logic [DIV_W-1:0] mir_div,
  output logic             rx_o,
  output logic             mir_rxbit_enable,
  output logic             rx_active
);

  logic             s1, s2, s3;
  logic             pstart;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] half;
  logic             pulse_seen;
  logic [3:0]       idle_cnt;
  logic [3:0]       idle_inc;
  logic             late_pulse;
  logic             cell_end;
  logic             close_cell;

  assign pstart     = s2 & ~s3;
  assign half       = mir_div >> 1;
  assign late_pulse = pstart && (cnt > half);
  // A pulse landing on the last count takes the late-pulse path, so cell_end excludes it.
  assign cell_end   = !pstart && (cnt == mir_div);
  assign close_cell = late_pulse | cell_end;
  assign idle_inc   = (idle_cnt == 4'd8) ? idle_cnt : idle_cnt + 4'd1;

  always_ff @(posedge clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= rx_pad_i ^ rx_invert;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      cnt              <= '0;
      pulse_seen       <= 1'b0;
      idle_cnt         <= 4'd0;
      rx_o             <= 1'b1;
      mir_rxbit_enable <= 1'b0;
      rx_active        <= 1'b0;
    end else if (!mir_en) begin
      cnt              <= '0;
      pulse_seen       <= 1'b0;
      idle_cnt         <= 4'd0;
      rx_o             <= 1'b1;
      mir_rxbit_enable <= 1'b0;
      rx_active        <= 1'b0;
    end else begin
      mir_rxbit_enable <= close_cell;
      if (close_cell)
        rx_o <= ~pulse_seen;

      if (pstart) begin
        cnt        <= DIV_W'(1);
        pulse_seen <= 1'b1;
      end else if (cell_end) begin
        cnt        <= '0;
        pulse_seen <= 1'b0;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end

      // Bit stuffing bounds the gap between pulses, so eight empty cells means the frame is over.
      if (pstart) begin
        rx_active <= 1'b1;
        idle_cnt  <= 4'd0;
      end else if (cell_end && !pulse_seen) begin
        idle_cnt <= idle_inc;
        if (idle_inc == 4'd8)
          rx_active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_irda_mir_rx_demod.sv
// tb/tb_irda_mir_rx_demod.sv - table-driven bench for irda_mir_rx_demod
module tb_irda_mir_rx_demod;

  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             wb_rst_n;
  logic             rx_pad_i;
  logic             rx_invert;
  logic             mir_en;
  logic [DIV_W-1:0] mir_div;
  logic             rx_o;
  logic             mir_rxbit_enable;
  logic             rx_active;

  irda_mir_rx_demod #(.DIV_W(DIV_W)) dut (
    .clk              (clk),
    .wb_rst_n         (wb_rst_n),
    .rx_pad_i         (rx_pad_i),
    .rx_invert        (rx_invert),
    .mir_en           (mir_en),
    .mir_div          (mir_div),
    .rx_o             (rx_o),
    .mir_rxbit_enable (mir_rxbit_enable),
    .rx_active        (rx_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   sc;
    int   cyc;
    logic bitv;
  } exp_t;

  exp_t tbl[$];
  int   got_cyc[$];
  logic got_bit[$];
  logic act_hist [512];
  int   pulse_starts[$];
  int   cyc_rel = 0;
  bit   mon_on = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  logic pat     [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  int   early_t [7] = '{30, 61, 93, 125, 157, 189, 221};
  int   late_t  [7] = '{32, 67, 99, 131, 163, 195, 227};

  // Strobes and activity are sampled on the falling edge, indexed by rising edges since release.
  always @(negedge clk) begin
    if (mon_on) begin
      if (cyc_rel >= 0 && cyc_rel < 512)
        act_hist[cyc_rel] = rx_active;
      if (mir_rxbit_enable) begin
        got_cyc.push_back(cyc_rel);
        got_bit.push_back(rx_o);
      end
    end
  end

  function automatic logic pulse_at(input int k);
    foreach (pulse_starts[i])
      if (k >= pulse_starts[i] && k < pulse_starts[i] + 8)
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic add(input int sc, input int cyc, input logic b);
    exp_t e;
    e.sc   = sc;
    e.cyc  = cyc;
    e.bitv = b;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic clear_capture();
    got_cyc.delete();
    got_bit.delete();
    foreach (act_hist[i])
      act_hist[i] = 1'b0;
  endtask

  task automatic do_reset(input logic inv);
    mon_on    = 1'b0;
    wb_rst_n  = 1'b0;
    mir_en    = 1'b1;
    rx_invert = inv;
    rx_pad_i  = inv;
    pulse_starts.delete();
    repeat (3) @(posedge clk);
    #1;
    wb_rst_n = 1'b1;
    cyc_rel  = 0;
    clear_capture();
    mon_on   = 1'b1;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc_rel++;
      rx_pad_i = pulse_at(cyc_rel) ^ rx_invert;
    end
  endtask

  task automatic check_scn(input int sc, input string nm);
    int k;
    k = 0;
    foreach (tbl[i]) begin
      if (tbl[i].sc == sc) begin
        if (k < got_cyc.size()) begin
          chk($sformatf("%s_cyc%0d", nm, k), got_cyc[k], tbl[i].cyc);
          chk($sformatf("%s_bit%0d", nm, k), int'(got_bit[k]), int'(tbl[i].bitv));
        end else begin
          chk($sformatf("%s_missing%0d", nm, k), -1, tbl[i].cyc);
        end
        k++;
      end
    end
    chk($sformatf("%s_count", nm), got_cyc.size(), k);
  endtask

  initial begin
    int ones;

    mir_div   = 8'd31;
    mir_en    = 1'b1;
    rx_invert = 1'b0;
    rx_pad_i  = 1'b0;
    wb_rst_n  = 1'b0;

    for (int i = 1; i <= 6; i++)  add(1, 32 * i, 1'b1);
    for (int i = 0; i < 7; i++)   add(2, 32 * (i + 1), pat[i]);
    for (int i = 8; i <= 14; i++) add(2, 32 * i, 1'b1);
    for (int i = 0; i < 7; i++)   add(3, early_t[i], pat[i]);
    for (int i = 0; i < 7; i++)   add(4, late_t[i], pat[i]);
    add(5, 32, 1'b1);
    add(5, 64, 1'b1);
    add(5, 95, 1'b0);
    add(5, 127, 1'b1);
    for (int i = 0; i < 7; i++)   add(6, 32 * (i + 1), pat[i]);
    add(7, 32, 1'b1);
    add(8, 32, 1'b1);

    @(posedge clk);
    #1;
    chk("reset_rx_o", int'(rx_o), 1);
    chk("reset_strobe", int'(mir_rxbit_enable), 0);
    chk("reset_active", int'(rx_active), 0);

    do_reset(1'b0);
    run_cycles(200);
    check_scn(1, "idle");
    ones = 0;
    for (int i = 1; i <= 200; i++)
      if (act_hist[i] === 1'b1) ones++;
    chk("idle_active_cycles", ones, 0);

    do_reset(1'b0);
    pulse_starts = '{30, 126, 158};
    run_cycles(460);
    check_scn(2, "pattern");
    chk("pattern_active_before", int'(act_hist[32]), 0);
    chk("pattern_active_after", int'(act_hist[33]), 1);
    chk("timeout_active_7th", int'(act_hist[447]), 1);
    chk("timeout_active_8th", int'(act_hist[448]), 0);

    do_reset(1'b0);
    pulse_starts = '{27, 123, 155};
    run_cycles(240);
    check_scn(3, "early");

    do_reset(1'b0);
    pulse_starts = '{33, 129, 161};
    run_cycles(240);
    check_scn(4, "late");

    do_reset(1'b0);
    pulse_starts = '{61};
    run_cycles(140);
    check_scn(5, "coincident");

    do_reset(1'b1);
    pulse_starts = '{30, 126, 158};
    run_cycles(240);
    check_scn(6, "invert");
    chk("invert_active_after", int'(act_hist[33]), 1);

    do_reset(1'b0);
    pulse_starts = '{30};
    run_cycles(80);
    chk("rstclr_pre_rx_o", int'(rx_o), 0);
    chk("rstclr_pre_active", int'(rx_active), 1);
    wb_rst_n = 1'b0;
    #1;
    chk("rstclr_rx_o", int'(rx_o), 1);
    chk("rstclr_strobe", int'(mir_rxbit_enable), 0);
    chk("rstclr_active", int'(rx_active), 0);
    do_reset(1'b0);
    run_cycles(40);
    check_scn(7, "rst_reenable");

    do_reset(1'b0);
    pulse_starts = '{30};
    run_cycles(80);
    chk("enclr_pre_rx_o", int'(rx_o), 0);
    chk("enclr_pre_active", int'(rx_active), 1);
    mir_en = 1'b0;
    run_cycles(1);
    chk("enclr_rx_o", int'(rx_o), 1);
    chk("enclr_strobe", int'(mir_rxbit_enable), 0);
    chk("enclr_active", int'(rx_active), 0);
    run_cycles(5);
    mir_en  = 1'b1;
    cyc_rel = 0;
    pulse_starts.delete();
    clear_capture();
    run_cycles(40);
    check_scn(8, "en_reenable");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
